// File: rtl/unified_mem_arbiter.sv
// Arbiter for one single-port unified instruction/data memory. Only one access is in flight at a time.
// Load/store has priority; a fetch wins after STARVE_LIM data grants taken while a fetch was waiting.
module unified_mem_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam int STV_W = $clog2(STARVE_LIM + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               win_f_q, win_f_d;
    logic               win_we_q, win_we_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [STV_W-1:0]   starve_q, starve_d;

    logic               if_gnt_q, if_gnt_d;
    logic               d_gnt_q, d_gnt_d;
    logic               if_rvalid_q, if_rvalid_d;
    logic               d_rvalid_q, d_rvalid_d;
    logic [31:0]        if_rdata_q, if_rdata_d;
    logic [31:0]        d_rdata_q, d_rdata_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [3:0]         mem_be_q, mem_be_d;
    logic               busy_q, busy_d;

    logic               pick_fetch;

    // Fetch wins when data is idle, or when it has been passed over STARVE_LIM times in a row.
    assign pick_fetch = if_req && (!d_req || (starve_q == STV_W'(STARVE_LIM)));

    always_comb begin
        state_d     = state_q;
        win_f_d     = win_f_q;
        win_we_d    = win_we_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;

        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    state_d  = ISSUE;
                    mem_en_d = 1'b1;
                    win_f_d  = pick_fetch;
                    if (pick_fetch) begin
                        if_gnt_d    = 1'b1;
                        win_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = 32'd0;
                        mem_be_d    = 4'hF;
                        starve_d    = '0;
                    end else begin
                        d_gnt_d     = 1'b1;
                        win_we_d    = d_we;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_be_d    = d_be;
                        if (!if_req) begin
                            starve_d = '0;
                        end else if (starve_q != STV_W'(STARVE_LIM)) begin
                            starve_d = starve_q + STV_W'(1);
                        end
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                lat_d   = LAT_W'(MEM_LAT);
            end
            WAIT: begin
                // Read data becomes valid during the last counted wait cycle.
                if (lat_q == LAT_W'(1)) begin
                    state_d = RESP;
                    if (win_f_q) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end else begin
                        d_rvalid_d = 1'b1;
                        if (!win_we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q     <= IDLE;
            win_f_q     <= 1'b0;
            win_we_q    <= 1'b0;
            lat_q       <= '0;
            starve_q    <= '0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_be_q    <= 4'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_f_q     <= win_f_d;
            win_we_q    <= win_we_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            busy_q      <= busy_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level schedule model and a shadow copy of memory.
module tb_unified_mem_arbiter;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_LIM = 4;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        busy;

    always #5 CLK = ~CLK;

    unified_mem_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_LIM(STARVE_LIM)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory macro: 256 words, byte-enabled writes, reads valid two cycles after mem_en.
    logic [31:0] mem_arr [256];
    logic [31:0] shadow  [256];
    logic [31:0] rd_pipe0, rd_pipe1;
    assign mem_rdata = rd_pipe1;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        end
        return r;
    endfunction

    always @(posedge CLK) begin
        if (mem_en && mem_we) mem_arr[mem_addr[9:2]] <= merge(mem_arr[mem_addr[9:2]], mem_wdata, mem_be);
        rd_pipe0 <= (mem_en && !mem_we) ? mem_arr[mem_addr[9:2]] : $urandom;
        rd_pipe1 <= rd_pipe0;
    end

    // Transaction-level model: when each access is accepted, issued and answered.
    int          cyc = 0;
    int          n_chk = 0, n_fail = 0;
    int          next_acc = 0, iss_cyc = -100, rsp_cyc = -100, rst_at = -100;
    int          starve = 0;
    bit          cur_f = 1'b0, cur_we = 1'b0;
    logic [31:0] cur_addr = '0, cur_wdata = '0, cur_data = '0;
    logic [3:0]  cur_be = '0;
    logic [31:0] exp_if_rdata = '0, exp_d_rdata = '0;
    bit          auto_drop = 1'b1;
    int          obs_ifg = -1, obs_ifv = -1, obs_dg = -1, obs_dv = -1;
    int          n_ifg = 0, n_dv = 0, n_memwe = 0;
    logic [3:0]  last_mem_be = '0;
    int          gq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        int e;
        bit pf;
        e = cyc + 1;
        if (!RSTn) begin
            rst_at = e; iss_cyc = -100; rsp_cyc = -100; next_acc = e + 1; starve = 0;
            exp_if_rdata = '0; exp_d_rdata = '0;
            return;
        end
        if (e == rsp_cyc) begin
            if (cur_f) exp_if_rdata = cur_data;
            else if (!cur_we) exp_d_rdata = cur_data;
        end
        if (e >= next_acc && (if_req || d_req)) begin
            pf = if_req && (!d_req || starve == STARVE_LIM);
            iss_cyc = e; rsp_cyc = e + MEM_LAT + 1; next_acc = e + MEM_LAT + 3; cur_f = pf;
            if (pf) begin
                cur_we = 1'b0; cur_addr = if_addr; cur_be = 4'hF; cur_wdata = '0; starve = 0;
            end else begin
                cur_we = d_we; cur_addr = d_addr; cur_be = d_be; cur_wdata = d_wdata;
                starve = if_req ? ((starve < STARVE_LIM) ? starve + 1 : starve) : 0;
            end
            if (cur_we) shadow[cur_addr[9:2]] = merge(shadow[cur_addr[9:2]], cur_wdata, cur_be);
            cur_data = shadow[cur_addr[9:2]];
        end
    endtask

    task automatic compare_cycle();
        bit isu, rsp;
        isu = (iss_cyc == cyc);
        rsp = (rsp_cyc == cyc);
        chk("if_gnt",    32'(if_gnt),    32'(isu && cur_f));
        chk("d_gnt",     32'(d_gnt),     32'(isu && !cur_f));
        chk("mem_en",    32'(mem_en),    32'(isu));
        chk("mem_we",    32'(mem_we),    32'(isu && cur_we));
        chk("if_rvalid", 32'(if_rvalid), 32'(rsp && cur_f));
        chk("d_rvalid",  32'(d_rvalid),  32'(rsp && !cur_f));
        chk("busy",      32'(busy),      32'(cyc >= iss_cyc && cyc <= rsp_cyc));
        chk("if_rdata",  if_rdata, exp_if_rdata);
        chk("d_rdata",   d_rdata,  exp_d_rdata);
        if (isu) begin
            chk("mem_addr",  mem_addr,      cur_addr);
            chk("mem_wdata", mem_wdata,     cur_wdata);
            chk("mem_be",    32'(mem_be),   32'(cur_be));
        end
        if (rst_at == cyc) begin
            chk("rst mem_addr",  mem_addr,    32'd0);
            chk("rst mem_wdata", mem_wdata,   32'd0);
            chk("rst mem_be",    32'(mem_be), 32'd0);
        end
        if (if_gnt)    begin obs_ifg = cyc; n_ifg++; gq.push_back(1); end
        if (d_gnt)     begin obs_dg = cyc; gq.push_back(0); end
        if (if_rvalid) obs_ifv = cyc;
        if (d_rvalid)  begin obs_dv = cyc; n_dv++; end
        if (mem_we)    n_memwe++;
        if (mem_en)    last_mem_be = mem_be;
    endtask

    task automatic tick();
        model_edge();
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
        compare_cycle();
        if (auto_drop) begin
            if (if_gnt) if_req = 1'b0;
            if (d_gnt)  d_req  = 1'b0;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [3:0] pick_be();
        logic [3:0] t [5];
        t = '{4'b0001, 4'b0011, 4'b1111, 4'b0100, 4'b1100};
        return t[$urandom_range(0, 4)];
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, snap;
        int exp_order [6];
        exp_order = '{0, 0, 0, 0, 1, 0};
        for (int i = 0; i < 256; i++) mem_arr[8'(i)] = 32'h5A5A0000 ^ (i * 32'h00010003);
        mem_arr[8'h40] = 32'hCAFE0100;
        mem_arr[8'h80] = 32'hD00D0200;
        mem_arr[8'h81] = 32'h11223344;
        for (int i = 0; i < 256; i++) shadow[8'(i)] = mem_arr[8'(i)];
        RSTn = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_be = '0;
        ticks(2);
        chk("reset busy", 32'(busy), 32'd0);
        RSTn = 1'b1;

        // Lone fetch from 0x100.
        base = cyc;
        if_req = 1'b1; if_addr = 32'h100;
        ticks(8);
        chk("T1 if_gnt cycle",    32'(obs_ifg - base), 32'd1);
        chk("T1 if_rvalid cycle", 32'(obs_ifv - base), 32'd4);
        chk("T1 mem_be",          32'(last_mem_be),    32'hF);
        chk("T1 if_rdata",        if_rdata,            32'hCAFE0100);

        // Simultaneous fetch and load: load first, fetch two cycles after its response.
        base = cyc;
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_be = 4'hF;
        ticks(12);
        chk("T2 d_gnt cycle",     32'(obs_dg - base),  32'd1);
        chk("T2 d_rvalid cycle",  32'(obs_dv - base),  32'd4);
        chk("T2 if_gnt cycle",    32'(obs_ifg - base), 32'd6);
        chk("T2 if_rvalid cycle", 32'(obs_ifv - base), 32'd9);
        chk("T2 d_rdata",         d_rdata,             32'hD00D0200);

        // Store byte to 0x204, then load it back.
        base = cyc; snap = n_memwe;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h204; d_be = 4'b0001; d_wdata = 32'hAB;
        ticks(7);
        chk("T3 mem_we pulses",   32'(n_memwe - snap), 32'd1);
        chk("T3 mem_be",          32'(last_mem_be),    32'h1);
        chk("T3 d_rvalid cycle",  32'(obs_dv - base),  32'd4);
        chk("T3 d_rdata held",    d_rdata,             32'hD00D0200);
        chk("T3 if_rdata held",   if_rdata,            32'hCAFE0100);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h204; d_be = 4'hF;
        ticks(7);
        chk("T3 readback",        d_rdata,             32'h112233AB);

        // Both requests held: fetch gets through on the fifth grant.
        gq.delete();
        auto_drop = 1'b0;
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_be = 4'hF;
        ticks(32);
        if_req = 1'b0; d_req = 1'b0; auto_drop = 1'b1;
        ticks(6);
        chk("T4 grant count >= 6", 32'(gq.size() >= 6), 32'd1);
        for (int i = 0; i < 6 && i < gq.size(); i++) chk("T4 grant order", 32'(gq[i]), 32'(exp_order[i]));

        // Reset during WAIT drops the access.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h204; d_be = 4'hF;
        ticks(2);
        chk("T5 busy in wait", 32'(busy), 32'd1);
        RSTn = 1'b0;
        tick();
        RSTn = 1'b1;
        snap = n_dv;
        chk("T5 busy after reset",  32'(busy), 32'd0);
        chk("T5 d_rdata cleared",   d_rdata,   32'd0);
        chk("T5 if_rdata cleared",  if_rdata,  32'd0);
        ticks(8);
        chk("T5 no late d_rvalid",  32'(n_dv), 32'(snap));

        // Fetch withdrawn while a load is in progress.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_be = 4'hF;
        tick();
        snap = n_ifg;
        if_req = 1'b1; if_addr = 32'h300;
        ticks(2);
        if_req = 1'b0;
        ticks(10);
        chk("T6 no fetch issued", 32'(n_ifg), 32'(snap));

        // Random traffic with occasional withdrawals and resets.
        for (int k = 0; k < 3000; k++) begin
            RSTn = ($urandom_range(0, 199) != 0);
            if (!if_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    if_req = 1'b1; if_addr = {22'h0, 8'($urandom), 2'b00};
                end
            end else if ($urandom_range(0, 15) == 0) begin
                if_req = 1'b0;
            end
            if (!d_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    d_req = 1'b1; d_we = 1'($urandom); d_addr = {22'h0, 8'($urandom), 2'b00};
                    d_wdata = $urandom; d_be = pick_be();
                end
            end else if ($urandom_range(0, 15) == 0) begin
                d_req = 1'b0;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
